// File: rtl/mop_thread_scheduler.sv
// Micro-op thread scheduler: expands instructions via the micro-op ROM and issues each micro-op per enabled thread; MOP_SCHED_PERF_CNT_EN adds issue/stall counters.
// Latency: accept -> first mop_valid 3 cycles later; 2-cycle bubble per micro-op boundary.
// Backpressure: mop/mop_tid hold while mop_valid & !mop_ready; instr_ready only in IDLE.

package CONTROL;
  typedef logic [6:0]  operation_t;
  typedef logic [16:0] ctrl_sig_t;

  typedef struct packed {
    logic [3:0] rsvd;
    logic [3:0] end_mop_cnt;
  } sub_op_t;

  typedef struct packed {
    operation_t op;
    sub_op_t    sub_op;
  } opcode_t;

  typedef struct packed {
    opcode_t    opcode;
    logic [6:0] dst;
    logic [6:0] src0;
    logic [6:0] src1;
  } instruction_t;

  typedef struct packed {
    ctrl_sig_t  csig;
    logic [9:0] dst;
    logic [9:0] src0;
    logic [9:0] src1;
  } micro_ops_t;
endpackage

module mop_thread_scheduler #(
  parameter int N_THREADS  = 6,
  parameter int BRAM_DEPTH = 10,
  parameter int TID_W      = 3,
  parameter int ROM_AW     = 11
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   instr_valid,
  output logic                                   instr_ready,
  input  logic [35:0]                            instr,
  input  logic [N_THREADS-1:0]                   thread_mask,
  output logic                                   rom_en,
  output logic [ROM_AW-1:0]                      rom_addr,
  input  logic [19:0]                            rom_rdata,
  output logic                                   mop_valid,
  input  logic                                   mop_ready,
  output logic [$bits(CONTROL::micro_ops_t)-1:0] mop,
  output logic [TID_W-1:0]                       mop_tid,
  output logic                                   instr_done,
`ifdef MOP_SCHED_PERF_CNT_EN
  output logic                                   busy,
  output logic [31:0]                            perf_issue_cnt,
  output logic [31:0]                            perf_stall_cnt
`else
  output logic                                   busy
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [6:0]             op_q, op_d;
  logic [3:0]             end_cnt_q, end_cnt_d;
  logic [6:0]             dst_q, dst_d, src0_q, src0_d, src1_q, src1_d;
  logic [N_THREADS-1:0]   mask_q, mask_d;
  logic [3:0]             mop_idx_q, mop_idx_d;
  logic [TID_W-1:0]       tid_q, tid_d;
  logic [16:0]            csig_q, csig_d;
  logic [2:0]             off_q, off_d;

  CONTROL::instruction_t  instr_s;
  CONTROL::micro_ops_t    mop_s;
  logic                   unused_rsvd;
  logic [TID_W-1:0]       first_tid_in, first_tid_q, next_tid;
  logic                   next_vld;
  logic                   hs;
  logic [6:0]             dst_sum, src0_sum, src1_sum;
  logic [BRAM_DEPTH-1:0]  dst_addr, src0_addr, src1_addr;

  assign instr_s     = instr;
  assign unused_rsvd = ^instr_s.opcode.sub_op.rsvd;
  assign hs          = (state_q == S_ISSUE) && mop_ready;

  // Descending scans so the final hit is the lowest qualifying thread.
  always_comb begin
    first_tid_in = '0;
    first_tid_q  = '0;
    next_tid     = '0;
    next_vld     = 1'b0;
    for (int i = N_THREADS - 1; i >= 0; i--) begin
      if (thread_mask[i]) first_tid_in = TID_W'(i);
      if (mask_q[i]) first_tid_q = TID_W'(i);
      if (mask_q[i] && (TID_W'(i) > tid_q)) begin
        next_tid = TID_W'(i);
        next_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    end_cnt_d = end_cnt_q;
    dst_d     = dst_q;
    src0_d    = src0_q;
    src1_d    = src1_q;
    mask_d    = mask_q;
    mop_idx_d = mop_idx_q;
    tid_d     = tid_q;
    csig_d    = csig_q;
    off_d     = off_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          op_d      = instr_s.opcode.op;
          end_cnt_d = instr_s.opcode.sub_op.end_mop_cnt;
          dst_d     = instr_s.dst;
          src0_d    = instr_s.src0;
          src1_d    = instr_s.src1;
          mask_d    = thread_mask;
          mop_idx_d = 4'd0;
          if (thread_mask == '0) begin
            state_d = S_DONE;
          end else begin
            tid_d   = first_tid_in;
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        csig_d  = rom_rdata[19:3];
        off_d   = rom_rdata[2:0];
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (mop_ready) begin
          if (next_vld) begin
            tid_d = next_tid;
          end else if (mop_idx_q == end_cnt_q) begin
            state_d = S_DONE;
          end else begin
            mop_idx_d = mop_idx_q + 4'd1;
            tid_d     = first_tid_q;
            state_d   = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      end_cnt_q <= '0;
      dst_q     <= '0;
      src0_q    <= '0;
      src1_q    <= '0;
      mask_q    <= '0;
      mop_idx_q <= '0;
      tid_q     <= '0;
      csig_q    <= '0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      end_cnt_q <= end_cnt_d;
      dst_q     <= dst_d;
      src0_q    <= src0_d;
      src1_q    <= src1_d;
      mask_q    <= mask_d;
      mop_idx_q <= mop_idx_d;
      tid_q     <= tid_d;
      csig_q    <= csig_d;
      off_q     <= off_d;
    end
  end

  // Offsets are single bits; address sums wrap within the 7-bit thread window.
  assign dst_sum   = dst_q  + {6'd0, off_q[2]};
  assign src0_sum  = src0_q + {6'd0, off_q[1]};
  assign src1_sum  = src1_q + {6'd0, off_q[0]};
  assign dst_addr  = {tid_q, dst_sum};
  assign src0_addr = {tid_q, src0_sum};
  assign src1_addr = {tid_q, src1_sum};

  always_comb begin
    mop_s      = '0;
    mop_s.csig = csig_q;
    mop_s.dst  = dst_addr;
    mop_s.src0 = src0_addr;
    mop_s.src1 = src1_addr;
  end

  assign mop         = mop_s;
  assign mop_tid     = tid_q;
  assign mop_valid   = (state_q == S_ISSUE);
  assign instr_ready = (state_q == S_IDLE);
  assign rom_en      = (state_q == S_FETCH);
  assign rom_addr    = {op_q, mop_idx_q};
  assign instr_done  = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);

`ifdef MOP_SCHED_PERF_CNT_EN
  logic [31:0] perf_issue_q, perf_issue_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issue_d = perf_issue_q;
    perf_stall_d = perf_stall_q;
    if (hs && (perf_issue_q != '1)) perf_issue_d = perf_issue_q + 32'd1;
    if (mop_valid && !mop_ready && (perf_stall_q != '1)) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_issue_q <= perf_issue_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_issue_cnt = perf_issue_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_mop_thread_scheduler.sv
// Directed bench for mop_thread_scheduler with a behavioural micro-op ROM and issue monitor.
module tb_mop_thread_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [35:0] instr;
  logic [5:0]  thread_mask;
  logic        rom_en;
  logic [10:0] rom_addr;
  logic [19:0] rom_rdata;
  logic        mop_valid;
  logic        mop_ready;
  logic [46:0] mop;
  logic [2:0]  mop_tid;
  logic        instr_done;
  logic        busy;
`ifdef MOP_SCHED_PERF_CNT_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  mop_thread_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .thread_mask(thread_mask),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .mop_valid(mop_valid), .mop_ready(mop_ready), .mop(mop), .mop_tid(mop_tid),
    .instr_done(instr_done),
`ifdef MOP_SCHED_PERF_CNT_EN
    .busy(busy), .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`else
    .busy(busy)
`endif
  );

  always #5 clk = ~clk;

  // ROM word = {6'b0, address, offsets}; csig therefore echoes the ROM address.
  logic [10:0] rom_addr_r = '0;
  logic [2:0]  off_cfg = '0;
  always @(posedge clk) if (rom_en) rom_addr_r <= rom_addr;
  assign rom_rdata = {6'b0, rom_addr_r, off_cfg};

  int          cyc = 0;
  int          done_cnt = 0;
  int          q_tid[$];
  int          q_cyc[$];
  logic [46:0] q_mop[$];
  logic [10:0] q_rom[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mop_valid && mop_ready) begin
      q_tid.push_back(int'(mop_tid));
      q_mop.push_back(mop);
      q_cyc.push_back(cyc);
    end
    if (rom_en) q_rom.push_back(rom_addr);
    if (instr_done) done_cnt++;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] mk_instr(input logic [6:0] op, input logic [3:0] endc,
                                           input logic [6:0] d, input logic [6:0] s0,
                                           input logic [6:0] s1);
    return {op, 4'h0, endc, d, s0, s1};
  endfunction

  task automatic send(input logic [35:0] i, input logic [5:0] m);
    int n = 0;
    while (!instr_ready && n < 50) begin step(); n++; end
    chk("send_ready", instr_ready, 1);
    instr = i;
    thread_mask = m;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin step(); n++; end
    chk(tag, busy, 0);
  endtask

  initial begin
    int b, r;
    int exp_tid[8];
    logic [31:0] stall0;
    rst_n = 1'b1; instr_valid = 1'b0; instr = '0; thread_mask = '0; mop_ready = 1'b1;
    #2 rst_n = 1'b0;
    step();
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_mop_valid", mop_valid, 0);
    chk("rst_rom_en", rom_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_mop", mop, 0);
    chk("rst_rom_addr", rom_addr, 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Single thread, end_mop_cnt=0, offsets dst/src0/src1 = 1/0/1.
    off_cfg = 3'b101;
    send(mk_instr(7'h12, 4'd0, 7'd5, 7'd9, 7'd10), 6'b000001);
    chk("t1_c1_rom_en", rom_en, 1);
    chk("t1_c1_rom_addr", rom_addr, 11'h120);
    chk("t1_c1_ready", instr_ready, 0);
    step();
    chk("t1_c2_valid", mop_valid, 0);
    step();
    chk("t1_c3_valid", mop_valid, 1);
    chk("t1_mop", mop, {17'h00120, 10'h006, 10'h009, 10'h00B});
    chk("t1_tid", mop_tid, 0);
    step();
    chk("t1_done", instr_done, 1);
    step();
    chk("t1_done_clr", instr_done, 0);
    chk("t1_ready", instr_ready, 1);

    // Six-thread mask 101101, two micro-ops.
    off_cfg = 3'b000;
    b = q_tid.size();
    r = q_rom.size();
    exp_tid = '{0, 2, 3, 5, 0, 2, 3, 5};
    send(mk_instr(7'h05, 4'd1, 7'd0, 7'd1, 7'd2), 6'b101101);
    wait_idle("t2_timeout");
    chk("t2_count", q_tid.size() - b, 8);
    if (q_tid.size() - b == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t2_tid", q_tid[b+i], exp_tid[i]);
        chk("t2_dst_hi", q_mop[b+i][29:27], exp_tid[i]);
        chk("t2_mop_idx", q_mop[b+i][33:30], i / 4);
      end
      chk("t2_b2b", q_cyc[b+1] - q_cyc[b], 1);
      chk("t2_bubble", q_cyc[b+4] - q_cyc[b+3], 3);
    end
    chk("t2_rom_cnt", q_rom.size() - r, 2);
    if (q_rom.size() - r == 2) begin
      chk("t2_rom0", q_rom[r], 11'h050);
      chk("t2_rom1", q_rom[r+1], 11'h051);
    end

    // Address wrap on thread 4.
    off_cfg = 3'b100;
    b = q_tid.size();
    send(mk_instr(7'h44, 4'd0, 7'd127, 7'd3, 7'd4), 6'b010000);
    wait_idle("t3_timeout");
    chk("t3_count", q_tid.size() - b, 1);
    if (q_tid.size() - b == 1) begin
      chk("t3_mop", q_mop[b], {17'h00440, 10'h200, 10'h203, 10'h204});
      chk("t3_tid", q_tid[b], 4);
    end

    // Backpressure: ready low for 4 cycles while thread 1 is offered.
    off_cfg = 3'b000;
    b = q_tid.size();
    send(mk_instr(7'h33, 4'd1, 7'd20, 7'd30, 7'd40), 6'b000111);
    begin
      int n = 0;
      while (!(mop_valid && mop_tid == 3'd1) && n < 50) begin step(); n++; end
    end
    chk("t4_reach", mop_tid, 1);
`ifdef MOP_SCHED_PERF_CNT_EN
    stall0 = perf_stall_cnt;
`else
    stall0 = '0;
`endif
    mop_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_hold_valid", mop_valid, 1);
      chk("t4_hold_mop", mop, {17'h00330, 10'h094, 10'h09E, 10'h0A8});
      chk("t4_hold_tid", mop_tid, 1);
    end
    mop_ready = 1'b1;
`ifdef MOP_SCHED_PERF_CNT_EN
    chk("t4_perf_stall", perf_stall_cnt - stall0, 4);
`endif
    wait_idle("t4_timeout");
    chk("t4_count", q_tid.size() - b, 6);
    if (q_tid.size() - b == 6) begin
      for (int i = 0; i < 6; i++) chk("t4_tid", q_tid[b+i], i % 3);
    end

    // Empty thread mask: straight to DONE.
    b = q_tid.size();
    r = q_rom.size();
    send(mk_instr(7'h01, 4'd2, 7'd0, 7'd0, 7'd0), 6'b000000);
    chk("t5_done", instr_done, 1);
    chk("t5_ready", instr_ready, 0);
    step();
    chk("t5_done_clr", instr_done, 0);
    chk("t5_ready_back", instr_ready, 1);
    chk("t5_no_mop", q_tid.size() - b, 0);
    chk("t5_no_rom", q_rom.size() - r, 0);

    // Reset while thread 3 is being offered.
    mop_ready = 1'b0;
    b = q_tid.size();
    send(mk_instr(7'h22, 4'd3, 7'd1, 7'd2, 7'd3), 6'b001000);
    begin
      int n = 0;
      while (!mop_valid && n < 50) begin step(); n++; end
    end
    chk("t6_valid", mop_valid, 1);
    chk("t6_tid", mop_tid, 3);
    r = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", mop_valid, 0);
    chk("t6_rst_ready", instr_ready, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_mop", mop, 0);
    chk("t6_rst_tid", mop_tid, 0);
    step(); step();
    rst_n = 1'b1;
    mop_ready = 1'b1;
    for (int k = 0; k < 20; k++) step();
    chk("t6_no_done", done_cnt - r, 0);
    chk("t6_no_mop", q_tid.size() - b, 0);
    chk("t6_ready", instr_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mop_thread_scheduler.md
Name: mop_thread_scheduler

Overview:
- Expands each accepted `instruction_t` into its micro-op sequence by reading the micro-op ROM.
- Issues every micro-op once per enabled thread, round-robin over `N_THREADS`, onto the shared Fp datapath port as `micro_ops_t`.
- Thread isolation comes from prefixing each 7-bit instruction address with the thread id, giving a `BRAM_DEPTH`-bit BRAM address.
- Sits between the instruction fetch/UART loader and the arithmetic core.

Parameters:
- `N_THREADS`, 6, number of hardware threads (1..8).
- `BRAM_DEPTH`, 10, datapath BRAM address width.
- `TID_W`, 3, thread id width; `BRAM_DEPTH` = `TID_W` + 7.
- `ROM_AW`, 11, micro-op ROM address width = 7-bit `operation_t` + 4-bit micro-op index.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  scheduler can accept.
- `instr`  in  36  `CONTROL::instruction_t`.
- `thread_mask`  in  `N_THREADS`  per-thread enable, sampled at accept.
- `rom_en`  out  1  micro-op ROM read strobe.
- `rom_addr`  out  `ROM_AW`  = {`op`, `mop_idx`}.
- `rom_rdata`  in  20  {`ctrl_sig_t` (17b), `off_dst`, `off_src0`, `off_src1`}; valid the cycle after `rom_en`.
- `mop_valid`  out  1  micro-op offered to datapath.
- `mop_ready`  in  1  datapath accepts.
- `mop`  out  `$bits(micro_ops_t)`  `CONTROL::micro_ops_t`.
- `mop_tid`  out  `TID_W`  thread of current micro-op.
- `instr_done`  out  1  one-cycle pulse, instruction fully issued.
- `busy`  out  1  state != IDLE.

Behaviour:
- Reset: state IDLE; all outputs 0 except `instr_ready`=1. All internal registers are cleared, including `mop_idx`, `tid` and the latched instruction. Reset mid-instruction abandons it silently, with no `instr_done`.
- FSM states: IDLE, FETCH, WAIT, ISSUE, DONE.
- IDLE: `instr_ready`=1. On `instr_valid` & `instr_ready`:
  - latch `instr` and `thread_mask`; set `mop_idx`=0.
  - if `thread_mask`==0, go to DONE (no ROM access, no micro-ops).
  - otherwise set `tid` to the lowest enabled thread and go to FETCH.
- FETCH: one cycle, `rom_en`=1, `rom_addr`={`instr.opcode.op`, `mop_idx`}. Then WAIT.
- WAIT: one cycle; capture `rom_rdata` into the csig/offset registers at the end of the cycle. Then ISSUE.
- ISSUE: `mop_valid`=1, with:
  - `mop.csig` = captured csig.
  - `mop.dst` = {`tid`, `instr.dst` + `off_dst`}; the 7-bit sum wraps mod 128, carry discarded.
  - `mop.src0` and `mop.src1` formed the same way from their instruction fields and offsets.
  - `mop_tid` = `tid`.
- Handshake: `mop`, `mop_tid` and `mop_valid` hold stable while `mop_valid` & !`mop_ready`. Handshake = `mop_valid` & `mop_ready`.
- On handshake:
  - if another enabled thread with a higher id exists, `tid` moves to the next enabled thread and the state stays ISSUE (back-to-back, one micro-op per cycle).
  - else if `mop_idx` == `instr.opcode.sub_op.end_mop_cnt`, go to DONE.
  - else `mop_idx`++, `tid` returns to the lowest enabled thread, go to FETCH.
- Issue order: micro-op-major, thread-minor (m0t0, m0t1, …, m1t0, …).
- Latency: accept at edge 0 → first `mop_valid` in cycle 3. Each micro-op boundary costs a 2-cycle bubble (FETCH + WAIT).
- `end_mop_cnt`=0 issues exactly 1 micro-op per enabled thread; `end_mop_cnt`=15 issues 16. `mop_idx` never wraps.
- DONE: `instr_done`=1 for one cycle, then IDLE. The next instruction can be accepted the cycle after DONE.
- `instr_ready`=0 in every state except IDLE; no instruction is accepted while `busy`.
- Threads with id ≥ `N_THREADS` never issue; `thread_mask` bits above `N_THREADS`-1 do not exist.

Optional Feature:
- Macro: `MOP_SCHED_PERF_CNT_EN`.
- Defined: adds outputs `perf_issue_cnt` [31:0] and `perf_stall_cnt` [31:0].
  - `perf_issue_cnt` counts micro-op handshakes.
  - `perf_stall_cnt` counts cycles with `mop_valid` & !`mop_ready`.
  - Both saturate at 2^32-1 and clear on reset.
- Undefined: those ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single thread: `instr.dst`=5, `src0`=9, `src1`=10, `end_mop_cnt`=0, `thread_mask`=6'b000001, ROM offsets 1/0/1, `mop_ready`=1 → one micro-op with `dst`=10'h006, `src0`=10'h009, `src1`=10'h00B. `mop_valid` first in cycle 3; `instr_done` pulses the cycle after the handshake.
- `thread_mask`=6'b101101, `end_mop_cnt`=1 → 8 micro-ops, tid order 0,2,3,5,0,2,3,5. Upper address bits equal tid; 2-cycle bubble between 5 and the second 0; `rom_addr` low nibble 0 then 1.
- Wrap: `instr.dst`=127, `off_dst`=1, tid=4 → `mop.dst`=10'h200.
- Backpressure: `mop_ready` low for 4 cycles mid-sequence → `mop`/`mop_tid` stable throughout, no micro-op lost or duplicated. With `MOP_SCHED_PERF_CNT_EN`, `perf_stall_cnt` increments by 4.
- `thread_mask`=0 → `instr_done` pulses 1 cycle after accept; `rom_en` and `mop_valid` never assert.
- `rst_n` low during ISSUE of tid 3 → outputs return to reset values immediately. After release, `instr_ready`=1 and no `instr_done` is produced for the abandoned instruction.
